smg_scan_control_module: RTL
============================

SMG_SCAN_CONTROL_MODULE -- requirements
Module: smg_scan_control_module

Interface
REQ-001 SHALL declare parameter T_SLOT, default 16'd49_999, digit ON-time minus one in CLK cycles (1 ms at 50 MHz).
REQ-002 SHALL declare parameter T_BLANK, default 8'd49, inter-digit blank time minus one in CLK cycles (1 us at 50 MHz).
REQ-003 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Number_Sig  input  24  six packed BCD digits; [3:0] is digit 0 (rightmost), [23:20] is digit 5.
REQ-006 SHALL have port DP_Sig  input  6  per-digit decimal point request, bit n for digit n, active-high.
REQ-007 SHALL have port SMG_Data  output  8  segment bus, active-low; bit7 = dp, bits6:0 = g..a.
REQ-008 SHALL have port Scan_Sig  output  6  digit select, active-low, bit n selects digit n.
REQ-009 SHALL have port Frame_Done  output  1  one-cycle pulse at end of each six-digit frame.

Function
REQ-010 SHALL time-share SMG_Data among six digits via a two-state FSM per slot: BLANK then ON.
REQ-011 SHALL in BLANK drive Scan_Sig = 6'b111111 and SMG_Data = 8'hFF for exactly T_BLANK+1 cycles.
REQ-012 SHALL in ON drive Scan_Sig with only bit[idx] low and SMG_Data = code of latched digit idx for exactly T_SLOT+1 cycles.
REQ-013 SHALL on ON expiry advance idx 0->1->...->5->0 and enter BLANK; frame length = 6*(T_SLOT+T_BLANK+2) cycles.
REQ-014 SHALL register Number_Sig and DP_Sig into frame registers only on the cycle ON of idx 5 expires; no mid-frame change is displayed (tear-free).
REQ-015 SHALL pulse Frame_Done high for exactly that latch cycle.
REQ-016 SHALL encode BCD 0-9 as C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp bit high).
REQ-017 SHALL encode digit values 10-15 as BF (segment g only, dash).
REQ-018 SHALL clear bit7 of SMG_Data when latched DP bit for idx is 1, including on dash digits.
REQ-019 SHALL register SMG_Data and Scan_Sig outputs; both change on the same edge as the FSM state.
REQ-020 SHALL keep the slot counter width sufficient for T_SLOT and T_BLANK; counters reset to 0 on each state change.

Reset
REQ-021 SHALL on RSTn low immediately set Scan_Sig = 6'b111111, SMG_Data = 8'hFF, Frame_Done = 0, idx = 0, state = BLANK, counter = 0, frame registers = 0.
REQ-022 SHALL after reset release start with BLANK of digit 0 displaying digit value 0 (frame registers), not live Number_Sig.
REQ-023 SHALL on reset mid-slot abandon the slot with no glitch cycle of any digit enabled.

Configuration
REQ-024 SHALL, with macro SMG_LEADING_ZERO_BLANK_EN defined, show 8'hFF (dp still honoured) for each digit n in 5..1 whose latched value and all higher latched digits are 0.
REQ-025 SHALL never blank digit 0; without SMG_LEADING_ZERO_BLANK_EN all six digits always display their code.
REQ-026 SHALL keep scan timing identical whether or not the macro is defined.

Structure
REQ-027 SHALL place segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and FSM state encodings in shared package smg_pkg.
REQ-028 SHALL implement BCD-to-segment lookup in combinational sub-module smg_encode_module (4-bit digit, dp in; 8-bit code out).

Verification (T_SLOT=9, T_BLANK=1; frame = 72 cycles)
REQ-029 SHALL check: reset release, Number_Sig=24'h123456 -> first frame shows C0 on every digit, Frame_Done at cycle 71, second frame digit0=82, digit5=F9.
REQ-030 SHALL check: steady scan -> each Scan_Sig low pattern lasts 10 cycles, separated by 2 cycles of 6'b111111 with SMG_Data=FF, never two bits low.
REQ-031 SHALL check: Number_Sig changed 24'h000001->24'h999999 mid-frame -> remainder of frame unchanged, next frame all digits 90.
REQ-032 SHALL check: Number_Sig=24'h00000A, DP_Sig=6'b000001 -> digit0 = 3F (dash plus dp), others C0 or FF per macro.
REQ-033 SHALL check: macro defined, Number_Sig=24'h000120 -> digits 5,4,3 = FF, digit2 F9, digit1 A4, digit0 C0; value 0 -> only digit0 C0.
REQ-034 SHALL check: RSTn asserted during ON of digit 3 -> same cycle Scan_Sig=111111, SMG_Data=FF, Frame_Done=0; restart at digit 0.

Source files
------------

// File: rtl/smg_pkg.sv
// smg_pkg
// Shared definitions for the six-digit seven-segment scan controller:
// active-low segment codes (bit7 = dp, bits6:0 = g..a), digit count and
// the scan FSM state encoding.
package smg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [5:0] SCAN_OFF = 6'b111111;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } smg_state_e;

endpackage

// File: rtl/smg_encode_module.sv
// smg_encode_module
// Combinational BCD to active-low seven-segment lookup. Values 10-15 show
// a dash (segment g only). A set dp request clears bit7, dashes included.
// Ports:
//   digit_i [3:0]  digit value
//   dp_i           decimal point request, active-high
//   code_o  [7:0]  segment code, active-low, bit7 = dp
module smg_encode_module
    import smg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dp_i,
    output logic [7:0] code_o
);

    logic [7:0] base;

    always_comb begin
        base = SEG_DASH;
        case (digit_i)
            4'd0: base = SEG_0;
            4'd1: base = SEG_1;
            4'd2: base = SEG_2;
            4'd3: base = SEG_3;
            4'd4: base = SEG_4;
            4'd5: base = SEG_5;
            4'd6: base = SEG_6;
            4'd7: base = SEG_7;
            4'd8: base = SEG_8;
            4'd9: base = SEG_9;
            default: base = SEG_DASH;
        endcase
    end

    assign code_o = {base[7] & ~dp_i, base[6:0]};

endmodule

// File: rtl/smg_scan_control_module.sv
// smg_scan_control_module
// Multiplexed driver for a six-digit common-anode seven-segment display.
// Each digit slot is a BLANK period (all digits off) followed by an ON
// period for the current digit. Display data comes from frame registers
// that are reloaded from the inputs only at the end of digit 5, so a frame
// never shows a mix of old and new values.
//
// Parameters:
//   T_SLOT   digit ON-time minus one, in CLK cycles
//   T_BLANK  inter-digit blank time minus one, in CLK cycles
// Ports:
//   CLK         system clock, rising edge
//   RSTn        asynchronous active-low reset
//   Number_Sig  six packed BCD digits, [3:0] = digit 0 (rightmost)
//   DP_Sig      per-digit decimal point request, active-high
//   SMG_Data    registered segment bus, active-low, bit7 = dp
//   Scan_Sig    registered digit select, active-low
//   Frame_Done  high during the last cycle of a frame (the frame-reload cycle)
//
// Build option: define SMG_LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 5..1 (dp still shown). Scan timing is the same either way.
//
//   state    | meaning
//   ST_BLANK | all digits off, SMG_Data = FF, lasts T_BLANK+1 cycles
//   ST_ON    | digit idx enabled with its code, lasts T_SLOT+1 cycles
module smg_scan_control_module
    import smg_pkg::*;
#(
    parameter logic [15:0] T_SLOT  = 16'd49_999,
    parameter logic [7:0]  T_BLANK = 8'd49
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Number_Sig,
    input  logic [5:0]  DP_Sig,
    output logic [7:0]  SMG_Data,
    output logic [5:0]  Scan_Sig,
    output logic        Frame_Done
);

    smg_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] num_q;
    logic [5:0]  dp_q;
    logic [7:0]  seg_q, seg_d;
    logic [5:0]  scan_q, scan_d;
    logic        latch;

    logic [3:0]  digit_sel;
    logic        dp_sel;
    logic [7:0]  enc_code;
    logic [5:0]  lz_blank;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        latch   = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == {8'd0, T_BLANK}) begin
                    state_d = ST_ON;
                    cnt_d   = 16'd0;
                end
            end
            ST_ON: begin
                if (cnt_q == T_SLOT) begin
                    state_d = ST_BLANK;
                    cnt_d   = 16'd0;
                    if (idx_q == 3'd5) begin
                        idx_d = 3'd0;
                        latch = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef SMG_LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every digit above it is zero; digit 0
    // always shows.
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
            zero_above  = zero_above & (num_q[n*4 +: 4] == 4'd0);
            lz_blank[n] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Outputs are computed from the next-state values so they change on the
    // same edge as the FSM. Frame registers only reload on entry to BLANK,
    // so they are stable whenever a digit is being turned on.
    assign digit_sel = num_q[{idx_d, 2'b00} +: 4];
    assign dp_sel    = dp_q[idx_d];

    smg_encode_module u_encode (
        .digit_i (digit_sel),
        .dp_i    (dp_sel),
        .code_o  (enc_code)
    );

    always_comb begin
        seg_d  = SEG_BLANK;
        scan_d = SCAN_OFF;
        if (state_d == ST_ON) begin
            scan_d = ~(6'b000001 << idx_d);
            if (lz_blank[idx_d]) begin
                seg_d = {~dp_sel, 7'h7F};
            end else begin
                seg_d = enc_code;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_BLANK;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            num_q   <= 24'd0;
            dp_q    <= 6'd0;
            seg_q   <= SEG_BLANK;
            scan_q  <= SCAN_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            scan_q  <= scan_d;
            if (latch) begin
                num_q <= Number_Sig;
                dp_q  <= DP_Sig;
            end
        end
    end

    // Decoded from registers only, and forced low by reset through state_q.
    assign Frame_Done = (state_q == ST_ON) && (idx_q == 3'd5) && (cnt_q == T_SLOT);
    assign SMG_Data   = seg_q;
    assign Scan_Sig   = scan_q;

endmodule
